// File: rtl/lane_scheduler.sv
// lane_scheduler: round-robin four-phase lane controller with pedestrian and emergency override (LANE_SKIP_EN skips empty phases)
module lane_scheduler #(
  parameter int GREEN_DAY   = 8,
  parameter int GREEN_NIGHT = 4,
  parameter int YELLOW_T    = 2,
  parameter int PED_T       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] laneCounts,
  input  logic        dayNightSignal,
  input  logic        pedSignal,
  input  logic        emgSignal,
  input  logic [7:0]  emgLane,
  output logic [7:0]  trafficLightOutput,
  output logic [7:0]  yellowLightOutput,
  output logic [7:0]  walkingLightOutput,
  output logic [1:0]  trafficMode,
  output logic [7:0]  currentCount
);
  typedef enum logic [2:0] {ALL_RED, GREEN, YELLOW, PED, EMG} state_t;
  state_t state;
  logic [1:0] phase;
  logic ped_pending;
  logic emg_q;
  logic found;
  logic [1:0] next_phase;
  assign emg_q = emgSignal && |emgLane;
`ifdef LANE_SKIP_EN
  logic [1:0] cand;
  // nearest phase after the current one that has traffic, wrapping back to itself last
  always_comb begin
    found = 1'b0;
    next_phase = phase + 2'd1;
    cand = phase;
    for (int i = 4; i >= 1; i--) begin
      cand = phase + 2'(i);
      if (|laneCounts[{cand, 4'b0000} +: 16]) begin
        found = 1'b1;
        next_phase = cand;
      end
    end
  end
`else
  logic unused_counts;
  assign unused_counts = ^laneCounts;
  // strict rotation: every phase is eligible
  always_comb begin
    found = 1'b1;
    next_phase = phase + 2'd1;
  end
`endif
  // state, phase, pending request and registered outputs advance together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ALL_RED;
      phase <= 2'd3;
      ped_pending <= 1'b0;
      currentCount <= 8'd0;
      trafficLightOutput <= 8'd0;
      yellowLightOutput <= 8'd0;
      walkingLightOutput <= 8'd0;
      trafficMode <= 2'b00;
    end else begin
      ped_pending <= ped_pending | pedSignal;
      trafficMode <= {1'b0, ~dayNightSignal};
      if (emg_q) begin
        state <= EMG;
        trafficLightOutput <= emgLane;
        yellowLightOutput <= 8'd0;
        walkingLightOutput <= 8'd0;
        currentCount <= 8'd0;
        trafficMode <= 2'b10;
      end else begin
        case (state)
          ALL_RED: begin
            if (ped_pending) begin
              state <= PED;
              ped_pending <= 1'b0;
              walkingLightOutput <= 8'hFF;
              trafficLightOutput <= 8'd0;
              yellowLightOutput <= 8'd0;
              currentCount <= 8'(PED_T - 1);
              trafficMode <= 2'b11;
            end else if (found) begin
              state <= GREEN;
              phase <= next_phase;
              trafficLightOutput <= 8'b11 << {next_phase, 1'b0};
              yellowLightOutput <= 8'd0;
              walkingLightOutput <= 8'd0;
              currentCount <= dayNightSignal ? 8'(GREEN_DAY - 1) : 8'(GREEN_NIGHT - 1);
            end else begin
              trafficLightOutput <= 8'd0;
              yellowLightOutput <= 8'd0;
              walkingLightOutput <= 8'd0;
              currentCount <= 8'd0;
            end
          end
          GREEN: begin
            if (currentCount == 8'd0) begin
              state <= YELLOW;
              yellowLightOutput <= trafficLightOutput;
              trafficLightOutput <= 8'd0;
              currentCount <= 8'(YELLOW_T - 1);
            end else currentCount <= currentCount - 8'd1;
          end
          YELLOW, PED: begin
            if (currentCount == 8'd0) begin
              state <= ALL_RED;
              yellowLightOutput <= 8'd0;
              walkingLightOutput <= 8'd0;
            end else begin
              currentCount <= currentCount - 8'd1;
              if (state == PED) trafficMode <= 2'b11;
            end
          end
          default: begin
            state <= ALL_RED;
            trafficLightOutput <= 8'd0;
            yellowLightOutput <= 8'd0;
            walkingLightOutput <= 8'd0;
            currentCount <= 8'd0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lane_scheduler.sv
// tb_lane_scheduler: randomized and directed checks of lane_scheduler against a segment-level reference model
module tb_lane_scheduler;
  localparam int GD = 8, GN = 4, YT = 2, PT = 6;
  logic clk = 0, rst = 1;
  logic [63:0] lane_counts = '0;
  logic day_night = 1, ped = 0, emg = 0;
  logic [7:0] emg_lane = '0;
  logic [7:0] traffic, yellow, walking, count;
  logic [1:0] mode;
  int total = 0, bad = 0;
  int kind, len, age, ph;
  bit pend;
  logic [7:0] elane;
  logic [1:0] m_mode;
  lane_scheduler #(.GREEN_DAY(GD), .GREEN_NIGHT(GN), .YELLOW_T(YT), .PED_T(PT)) dut (
    .clk(clk), .rst(rst), .laneCounts(lane_counts), .dayNightSignal(day_night),
    .pedSignal(ped), .emgSignal(emg), .emgLane(emg_lane),
    .trafficLightOutput(traffic), .yellowLightOutput(yellow), .walkingLightOutput(walking),
    .trafficMode(mode), .currentCount(count));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit eligible(input int p);
`ifdef LANE_SKIP_EN
    return lane_counts[16*p +: 16] != 0;
`else
    return 1;
`endif
  endfunction
  task automatic model_reset();
    kind = 0; len = 0; age = 0; ph = 3; pend = 0; elane = 0; m_mode = 0;
  endtask
  task automatic start(input int k, input int l);
    kind = k; len = l; age = 0;
  endtask
  task automatic model_step();
    bit pend_old;
    bit picked;
    pend_old = pend;
    pend = pend | ped;
    if (emg && emg_lane != 0) begin
      start(4, 0);
      elane = emg_lane;
    end else if (kind inside {1, 2, 3} && age + 1 < len) age++;
    else if (kind == 1) start(2, YT);
    else if (kind != 0) start(0, 0);
    else if (pend_old) begin
      start(3, PT);
      pend = 0;
    end else begin
      picked = 0;
      for (int k = 1; k <= 4; k++)
        if (!picked && eligible((ph + k) % 4)) begin
          picked = 1;
          ph = (ph + k) % 4;
        end
      if (picked) start(1, day_night ? GD : GN);
    end
    m_mode = kind == 4 ? 2'b10 : kind == 3 ? 2'b11 : (day_night ? 2'b00 : 2'b01);
  endtask
  task automatic compare_all();
    logic [7:0] pair;
    pair = 8'(3 << (2 * ph));
    chk("traffic", traffic, kind == 1 ? pair : kind == 4 ? elane : 8'h00);
    chk("yellow", yellow, kind == 2 ? pair : 8'h00);
    chk("walking", walking, kind == 3 ? 8'hFF : 8'h00);
    chk("mode", mode, m_mode);
    chk("count", count, kind inside {1, 2, 3} ? 8'(len - 1 - age) : 8'h00);
  endtask
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    compare_all();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; ped = 0; emg = 0; emg_lane = 0;
    model_reset();
    #1 compare_all();
    cyc();
    rst = 0;
  endtask
  initial begin
    int guard;
    lane_counts = {8{8'd5}};
    do_reset();
    cyc();
    chk("first_green", traffic, 8'h03);
    chk("first_count", count, 8'd7);
    repeat (10) cyc();
    cyc();
    chk("second_green", traffic, 8'h0C);
    day_night = 0;
    repeat (30) cyc();
    chk("night_mode", mode, 2'b01);
    day_night = 1;
    do_reset();
    repeat (12) cyc();
    ped = 1;
    cyc();
    ped = 0;
    repeat (25) cyc();
    do_reset();
    repeat (4) cyc();
    emg = 1; emg_lane = 8'h08;
    cyc();
    chk("emg_lane08", traffic, 8'h08);
    chk("emg_mode", mode, 2'b10);
    emg_lane = 8'h30;
    cyc();
    chk("emg_lane30", traffic, 8'h30);
    emg = 0;
    cyc();
    chk("emg_exit_red", traffic, 8'h00);
    cyc();
    chk("emg_resume", traffic, 8'h0C);
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) day_night = ~day_night;
      ped = $urandom_range(0, 24) == 0;
      if (!emg) emg = $urandom_range(0, 59) == 0;
      else emg = $urandom_range(0, 5) != 0;
      emg_lane = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
      lane_counts = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) lane_counts[31:0] = 0;
      cyc();
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    emg = 0; ped = 0;
    do_reset();
    emg = 1; emg_lane = 8'h00; ped = 1;
    cyc();
    emg = 0; ped = 0;
    guard = 0;
    while (kind != 3 && guard < 40) begin
      cyc();
      guard++;
    end
    chk("ped_reached", walking, 8'hFF);
    cyc();
    @(negedge clk);
    rst = 1;
    model_reset();
    #1 chk("reset_in_ped", walking, 8'h00);
    compare_all();
    cyc();
    rst = 0;
    repeat (20) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
